// File: rtl/sata_srst_seq_pkg.sv
// Shared constants for the SATA soft-reset sequencer: FIS types, SRST control bit,
// H2D frame length, sequencer state encoding and counter sizing helper.
package sata_srst_seq_pkg;

    localparam logic [7:0] FIS_TYPE_H2D = 8'h27;
    localparam logic [7:0] FIS_TYPE_D2H = 8'h34;
    localparam int         SRST_BIT     = 2;
    localparam int         FIS_LEN      = 5;

    // Control byte sits in the top byte of H2D word 3
    localparam logic [31:0] CTRL_SRST = 32'(1) << (24 + SRST_BIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_SET,
        ST_HOLD,
        ST_SEND_CLR,
        ST_WAIT_D2H,
        ST_DONE,
        ST_FAIL
    } state_t;

    function automatic int cnt_width(input int n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sata_fis_tx5.sv
// Five-word frame sender with valid/ready handshake; start loads word 0,
// done pulses in the cycle the last word is accepted.
module sata_fis_tx5
    import sata_srst_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [31:0] w2,
    input  logic [31:0] w3,
    input  logic [31:0] w4,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic        done
);

    localparam logic [2:0] LAST_IDX = 3'(FIS_LEN - 1);

    logic [2:0] idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            idx     <= '0;
        end else if (start) begin
            m_valid <= 1'b1;
            idx     <= '0;
        end else if (m_valid && m_ready) begin
            if (idx == LAST_IDX) begin
                m_valid <= 1'b0;
                idx     <= '0;
            end else begin
                idx <= idx + 3'd1;
            end
        end
    end

    always_comb begin
        m_data = '0;
        if (m_valid) begin
            case (idx)
                3'd0:    m_data = w0;
                3'd1:    m_data = w1;
                3'd2:    m_data = w2;
                3'd3:    m_data = w3;
                3'd4:    m_data = w4;
                default: m_data = '0;
            endcase
        end
    end

    assign m_last = m_valid && (idx == LAST_IDX);
    assign done   = m_valid && m_ready && m_last;

endmodule

// File: rtl/sata_srst_seq.sv
// SATA soft-reset sequencer: SRST set FIS, hold, SRST clear FIS, then wait for
// the D2H Register FIS carrying the device signature, retrying on timeout.
module sata_srst_seq
    import sata_srst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int TIMEOUT     = 1000000,
    parameter int RETRIES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [3:0]  i_pmport,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_sig,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    input  logic        s_last
);

    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int TW = cnt_width(TIMEOUT);
    localparam int RW = cnt_width(RETRIES);
    localparam logic [2:0] RX_SAT = 3'(FIS_LEN);

    state_t        state, state_nxt;
    logic [3:0]    pmport;
    logic [HW-1:0] h_cnt;
    logic [TW-1:0] t_cnt;
    logic [RW-1:0] r_cnt;
    logic          tx_start, tx_done;
    logic [2:0]    rx_idx;
    logic          rx_good;
    logic [23:0]   rx_w1;
    logic [7:0]    rx_w3;
    logic          rx_qual, timeout_hit;
    logic [31:0]   w0, w3;

    assign w0 = {16'h0000, 4'h0, pmport, FIS_TYPE_H2D};
    assign w3 = (state == ST_SEND_SET) ? CTRL_SRST : 32'h0;

    sata_fis_tx5 u_tx (
        .clk     (clk),
        .reset   (reset),
        .start   (tx_start),
        .w0      (w0),
        .w1      (32'h0),
        .w2      (32'h0),
        .w3      (w3),
        .w4      (32'h0),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .done    (tx_done)
    );

    // Frames whose word 0 arrived outside WAIT_D2H never get rx_good set
    assign rx_qual     = (state == ST_WAIT_D2H) && s_valid && s_last && rx_good &&
                         (rx_idx == 3'(FIS_LEN - 1));
    assign timeout_hit = (state == ST_WAIT_D2H) && (t_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        case (state)
            ST_IDLE: if (i_start) begin
                state_nxt = ST_SEND_SET;
                tx_start  = 1'b1;
            end
            ST_SEND_SET: if (tx_done) state_nxt = ST_HOLD;
            ST_HOLD: if (h_cnt <= HW'(1)) begin
                state_nxt = ST_SEND_CLR;
                tx_start  = 1'b1;
            end
            ST_SEND_CLR: if (tx_done) state_nxt = ST_WAIT_D2H;
            ST_WAIT_D2H: begin
                if (rx_qual) begin
                    state_nxt = ST_DONE;
                end else if (timeout_hit) begin
                    if (r_cnt != '0) begin
                        state_nxt = ST_SEND_SET;
                        tx_start  = 1'b1;
                    end else begin
                        state_nxt = ST_FAIL;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_FAIL: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_busy = (state != ST_IDLE);
    assign o_done = (state == ST_DONE);
    assign o_err  = (state == ST_FAIL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            pmport <= '0;
            h_cnt  <= '0;
            t_cnt  <= '0;
            r_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && i_start) begin
                pmport <= i_pmport;
                r_cnt  <= RW'(RETRIES);
            end else if (timeout_hit && !rx_qual && r_cnt != '0) begin
                r_cnt <= r_cnt - RW'(1);
            end
            if (state == ST_SEND_SET)
                h_cnt <= HW'(HOLD_CYCLES);
            else if (state == ST_HOLD && h_cnt != '0)
                h_cnt <= h_cnt - HW'(1);
            if (state == ST_WAIT_D2H && !timeout_hit)
                t_cnt <= t_cnt + TW'(1);
            else
                t_cnt <= '0;
        end
    end

    // Receive tracking runs in every state so in-flight frames are skipped cleanly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_idx  <= '0;
            rx_good <= 1'b0;
            rx_w1   <= '0;
            rx_w3   <= '0;
            o_sig   <= '0;
        end else begin
            if (s_valid) begin
                if (s_last)
                    rx_idx <= '0;
                else if (rx_idx != RX_SAT)
                    rx_idx <= rx_idx + 3'd1;
                if (rx_idx == 3'd0)
                    rx_good <= (state == ST_WAIT_D2H) && (s_data[7:0] == FIS_TYPE_D2H);
                if (rx_idx == 3'd1)
                    rx_w1 <= s_data[23:0];
                if (rx_idx == 3'd3)
                    rx_w3 <= s_data[7:0];
            end
            if (rx_qual)
                o_sig <= {rx_w1, rx_w3};
        end
    end

endmodule

// File: tb/tb_sata_srst_seq.sv
// Self-checking bench for sata_srst_seq: H2D word scoreboard, table of D2H replies,
// hand-written hold-gap, timeout/retry and mid-frame reset sequences.
module tb_sata_srst_seq;

    localparam int HOLD = 16;
    localparam int TMO  = 100;
    localparam int RTR  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic [3:0]  i_pmport = 4'h0;
    logic        o_busy, o_done, o_err;
    logic [31:0] o_sig;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        m_last;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        s_last = 1'b0;

    always #5 clk = ~clk;

    sata_srst_seq #(.HOLD_CYCLES(HOLD), .TIMEOUT(TMO), .RETRIES(RTR)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_start  (i_start),
        .i_pmport (i_pmport),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err),
        .o_sig    (o_sig),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected H2D words: {m_last, m_data}
    logic [32:0] sb[$];

    task automatic push_frame(input logic [3:0] p, input bit srst);
        for (int i = 0; i < 5; i++) begin
            logic [31:0] d;
            d = 32'h0;
            if (i == 0) d = {20'h00000, p, 8'h27};
            if (i == 3 && srst) d = 32'h0400_0000;
            sb.push_back({(i == 4), d});
        end
    endtask

    task automatic push_seq(input logic [3:0] p);
        push_frame(p, 1'b1);
        push_frame(p, 1'b0);
    endtask

    int          done_cnt = 0;
    int          err_cnt  = 0;
    bit          stalled  = 1'b0;
    logic [32:0] held;

    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (o_done) done_cnt++;
            if (o_err)  err_cnt++;
            if (m_valid) begin
                if (stalled) check("stall_hold", {m_last, m_data}, held);
                if (m_ready) begin
                    logic [32:0] exp;
                    exp = (sb.size() != 0) ? sb.pop_front() : 33'h1_FFFF_FFFF;
                    check("h2d_word", {m_last, m_data}, exp);
                    stalled = 1'b0;
                end else if (!stalled) begin
                    stalled = 1'b1;
                    held    = {m_last, m_data};
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    bit rdy_random = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        m_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic start_seq(input logic [3:0] p);
        @(posedge clk);
        #1;
        i_pmport = p;
        i_start  = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        push_seq(p);
    endtask

    task automatic wait_sb_depth(input int depth, input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() != depth && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, sb.size(), depth);
    endtask

    task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w3, input int len);
        @(posedge clk);
        #1;
        for (int i = 0; i < len; i++) begin
            s_valid = 1'b1;
            s_data  = (i == 0) ? w0 : (i == 1) ? w1 : (i == 3) ? w3 : 32'h0;
            s_last  = (i == len - 1);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 32'h0;
    endtask

    task automatic wait_outcome(input int budget, output int dd, output int ed);
        int d0, e0, n;
        d0 = done_cnt;
        e0 = err_cnt;
        n  = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #1;
        dd = done_cnt - d0;
        ed = err_cnt - e0;
    endtask

    typedef struct {
        logic [3:0]  pm;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w3;
        int          len;
        bit          good;
        logic [31:0] sig;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int dd, ed, gap;

        tbl[0] = '{4'h1, 32'h0050_0034, 32'h00EB_1401, 32'h0000_0001, 5, 1'b1, 32'hEB14_0101};
        tbl[1] = '{4'h7, 32'h0050_0039, 32'h00FF_FFFF, 32'h0000_00FF, 5, 1'b0, 32'hA1B2_C35D};
        tbl[2] = '{4'hA, 32'h0050_0034, 32'h00FF_FFFF, 32'h0000_00FF, 4, 1'b0, 32'hA1B2_C35D};
        tbl[3] = '{4'hC, 32'h0050_0034, 32'h00FF_FFFF, 32'h0000_00FF, 6, 1'b0, 32'hA1B2_C35D};
        tbl[4] = '{4'hE, 32'h0050_0034, 32'h0012_3456, 32'h0000_00AB, 5, 1'b1, 32'h1234_56AB};

        repeat (3) @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_o_done", o_done, 0);
        check("rst_o_err", o_err, 0);
        check("rst_o_sig", o_sig, 0);
        check("rst_o_busy", o_busy, 0);
        reset = 1'b0;

        // Set FIS, exact hold gap, clear FIS, signature reply
        start_seq(4'h3);
        wait_sb_depth(5, 50, "set_frame_words");
        gap = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_valid) break;
            gap++;
        end
        check("hold_gap", gap, HOLD);
        wait_sb_depth(0, 50, "clr_frame_words");
        send_frame(32'h0050_0034, 32'h00EB_1401, 32'h0000_0001, 5);
        wait_outcome(300, dd, ed);
        check("seq1_done", dd, 1);
        check("seq1_err", ed, 0);
        check("seq1_sig", o_sig, 32'hEB14_0101);
        check("seq1_busy", o_busy, 0);

        // Reply table under random m_ready stalls
        rdy_random = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start_seq(tbl[i].pm);
            wait_sb_depth(0, 400, "tbl_words");
            send_frame(tbl[i].w0, tbl[i].w1, tbl[i].w3, tbl[i].len);
            if (!tbl[i].good) begin
                push_seq(tbl[i].pm);
                wait_sb_depth(0, 800, "tbl_retry_words");
                send_frame(32'h0050_0034, 32'h00A1_B2C3, 32'h0000_005D, 5);
            end
            wait_outcome(800, dd, ed);
            check("tbl_done", dd, 1);
            check("tbl_err", ed, 0);
            check("tbl_sig", o_sig, tbl[i].sig);
            check("tbl_busy", o_busy, 0);
        end
        rdy_random = 1'b0;

        // No reply: all retries used, single error pulse; start while busy is ignored
        start_seq(4'h9);
        push_seq(4'h9);
        push_seq(4'h9);
        repeat (3) @(posedge clk);
        #1;
        i_pmport = 4'hF;
        i_start  = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_outcome(1500, dd, ed);
        check("noreply_err", ed, 1);
        check("noreply_done", dd, 0);
        check("noreply_words_left", sb.size(), 0);
        check("noreply_busy", o_busy, 0);
        check("noreply_sig_held", o_sig, tbl[4].sig);
        sb.delete();

        // Reset while clear FIS word 2 is on the bus
        start_seq(4'h5);
        wait_sb_depth(3, 100, "pre_reset_words");
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_m_valid", m_valid, 0);
        sb.delete();
        @(negedge clk);
        check("rst2_m_data", m_data, 0);
        check("rst2_o_sig", o_sig, 0);
        check("rst2_o_busy", o_busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle_valid", m_valid, 0);
        start_seq(4'h5);
        wait_sb_depth(0, 100, "post_rst_words");
        send_frame(32'h0050_0034, 32'h00EB_1401, 32'h0000_0001, 5);
        wait_outcome(300, dd, ed);
        check("post_rst_done", dd, 1);
        check("post_rst_sig", o_sig, 32'hEB14_0101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
